// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised register file with bypass and pending-write scoreboard
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    output logic                         any_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_any_busy;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic [DEPTH-1:0]  w_busy_nxt;

    assign w_wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign w_rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Reservation is applied after the clear so a new producer wins a same-address collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_any_busy <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_busy     <= w_busy_nxt;
            r_any_busy <= |w_busy_nxt;
        end
    end

    assign any_busy = r_any_busy;

    genvar k;
    generate
        for (k = 0; k < NUM_READ; k++) begin : g_rd
            logic [ADDR_W-1:0] w_a;
            logic              w_zero;
            logic              w_fwd;

            assign w_a    = rd_addr[k*ADDR_W +: ADDR_W];
            assign w_zero = (ZERO_REG != 0) && (w_a == '0);
            // A forwarded value is already current, so the port is not reported busy.
            assign w_fwd  = (BYPASS != 0) && wr_en && (wr_addr == w_a);

            assign rd_data[k*DATA_W +: DATA_W] = w_zero ? '0 :
                                                 w_fwd  ? wr_data : r_mem[w_a];
            assign rd_busy[k] = !w_zero && !w_fwd && r_busy[w_a];
        end
    endgenerate

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the CPU datapath, successor to the fixed 32x32 two-read/one-write file. It adds configurable width, depth and read-port count, an optional hard-wired zero register, and write-to-read bypass. A per-register pending-write scoreboard lets the control unit reserve a destination and stall consumers until the producing write lands.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_READ, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- Clk  input  1  rising-edge clock, single clock domain
- Rst_n  input  1  asynchronous active-low reset
- rd_addr  input  NUM_READ*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NUM_READ*DATA_W  read data, port k in bits [k*DATA_W +: DATA_W]
- rd_busy  output  NUM_READ  1 = register on port k has an outstanding reservation
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rsv_en  input  1  reserve (mark pending) rsv_addr
- rsv_addr  input  ADDR_W  register being reserved
- any_busy  output  1  OR of all busy bits (registered)

## Operation
- Storage: array of 2**ADDR_W entries of DATA_W bits plus busy vector of 2**ADDR_W bits.
- Reset (Rst_n=0, asynchronous): all entries 0, all busy bits 0, any_busy 0; held while low.
- Write: on posedge with wr_en=1, entry[wr_addr] <= wr_data and busy[wr_addr] <= 0. If ZERO_REG and wr_addr=0: no effect.
- Reserve: on posedge with rsv_en=1, busy[rsv_addr] <= 1. If ZERO_REG and rsv_addr=0: ignored.
- Simultaneous wr_en and rsv_en, same address: data written and busy ends 1 (new producer wins). Different addresses: both take effect.
- Read (combinational, per port k): if ZERO_REG and addr=0 -> 0; else if BYPASS and wr_en and wr_addr=addr -> wr_data; else entry[addr].
- rd_busy[k]: busy[addr]; forced 0 if BYPASS and wr_en and wr_addr=addr (value is being forwarded); forced 0 for address 0 when ZERO_REG. Same-cycle rsv_en does not affect rd_busy until the next cycle.
- Write to a non-busy register is legal; it simply clears nothing.
- All read ports are independent; identical addresses on several ports return identical data.
- any_busy: registered OR of the next-state busy vector, updated on every posedge.

## Timing
- Write latency: data visible from array on the cycle after the write edge; with BYPASS=1 visible combinationally in the write cycle.
- Reserve latency: busy visible on rd_busy one cycle after rsv_en edge.
- Read path purely combinational from rd_addr/wr_* to rd_data/rd_busy; no clocked read latency.
- Reset assertion mid-write: write discarded, outputs return to reset values without waiting for Clk; first write accepted on the first posedge after Rst_n rises.
- No wrap-around: addresses cover full depth exactly; no undefined entries.

## Test plan
- Reset: load reg 5 = 0xDEADBEEF, pulse Rst_n low between clocks -> rd_data for addr 5 = 0 immediately, rd_busy=0, any_busy=0.
- Write/read: write reg 3 = 0x12345678, next cycle read ports 0 and 1 both addr 3 -> both 0x12345678; with BYPASS=1 value appears in write cycle, with BYPASS=0 only the cycle after.
- Zero register: write reg 0 = 0xFFFFFFFF and rsv_en addr 0 -> reads return 0, rd_busy=0, any_busy=0.
- Scoreboard: rsv_en addr 7 -> next cycle rd_busy=1, any_busy=1; wr_en addr 7 = 0xA5 -> rd_busy=0 in that cycle (bypass), any_busy=0 after edge.
- Collision: same cycle rsv_en addr 9 and wr_en addr 9 = 0x55 -> next cycle data 0x55, rd_busy=1.
- Parametrisation: DATA_W=16, ADDR_W=3, NUM_READ=4: write reg k = k*0x1111 for k=1..7, read all four ports with distinct addresses -> each returns its value.
